// File: rtl/frame_pwm.sv
// frame_pwm: double-buffered pixel store with per-channel PWM output.
//
// A display driver sweeps row/column/cycle; this block returns the lit/unlit
// state of the upper-half (line = row) and lower-half (line = row + rows)
// pixels at that column. Pixels are written into the back bank through a
// valid/ready port. A swap request becomes pending and is committed at the
// next frame boundary (cycle wrapping from cycles-1 to 0).
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous, active-low reset
//   row           current row address from the display driver
//   column        current column from the display driver
//   cycle         current PWM cycle from the display driver
//   wr_valid      write request
//   wr_ready      write accept (low while a swap is pending)
//   wr_addr       pixel address, line * columns + pixel
//   wr_data       {red, green, blue}, CW bits each
//   swap_req      single-cycle commit request for the back bank
//   swap_pending  commit accepted, waiting for the frame boundary
//   swap_done     one-cycle pulse on buffer exchange
//   r0 g0 b0      upper-half pixel bits
//   r1 g1 b1      lower-half pixel bits
//
// Swap FSM:
//   state     | meaning
//   S_IDLE    | no commit outstanding, writes accepted
//   S_PENDING | commit accepted, writes stalled, waiting for frame boundary

module frame_pwm #(
  parameter int rows    = 8,
  parameter int columns = 32,
  parameter int cycles  = 256,
  localparam int CW     = (cycles > 1) ? $clog2(cycles) : 1,
  localparam int RW     = (rows > 1) ? $clog2(rows) : 1,
  localparam int CLW    = (columns > 1) ? $clog2(columns) : 1,
  localparam int DEPTH  = 2 * rows * columns,
  localparam int AW     = $clog2(DEPTH),
  localparam int DW     = 3 * CW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RW-1:0]  row,
  input  logic [CLW-1:0] column,
  input  logic [CW-1:0]  cycle,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           swap_req,
  output logic           swap_pending,
  output logic           swap_done,
  output logic           r0,
  output logic           g0,
  output logic           b0,
  output logic           r1,
  output logic           g1,
  output logic           b1
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } swap_state_t;

  swap_state_t   state;
  logic          front_sel;
  logic [CW-1:0] prev_cycle;

  // Bank index first, pixel address second. Not reset: contents are
  // undefined until written.
  logic [DW-1:0] mem [2][DEPTH];

  logic          wr_in_range;
  logic          wr_en;
  logic          boundary;
  logic [31:0]   addr_hi;
  logic [31:0]   addr_lo;
  logic [DW-1:0] pix_hi;
  logic [DW-1:0] pix_lo;

  assign swap_pending = (state == S_PENDING);
  assign wr_ready     = ~swap_pending;

  // Out-of-range addresses still complete the handshake; they just store
  // nothing. Holding the write off while rst is low drops any transfer that
  // had not completed before reset asserted.
  assign wr_in_range = ({{(32-AW){1'b0}}, wr_addr} < 32'(DEPTH));
  assign wr_en       = wr_valid & wr_ready & wr_in_range & rst;

  assign boundary = (prev_cycle == CW'(cycles - 1)) && (cycle == '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[~front_sel][wr_addr] <= wr_data;
    end
  end

  // Two independent reads of the front bank. Addresses past the end of the
  // store (possible when row/column exceed their ranges) read as zero rather
  // than indexing outside the array.
  always_comb begin
    addr_hi = 32'(row) * 32'(columns) + 32'(column);
    addr_lo = (32'(row) + 32'(rows)) * 32'(columns) + 32'(column);
    pix_hi  = '0;
    pix_lo  = '0;
    if (addr_hi < 32'(DEPTH)) begin
      pix_hi = mem[front_sel][addr_hi[AW-1:0]];
    end
    if (addr_lo < 32'(DEPTH)) begin
      pix_lo = mem[front_sel][addr_lo[AW-1:0]];
    end
  end

  // Outputs sample the pre-toggle front bank on a swap edge, because
  // front_sel only changes after that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0 <= 1'b0;
      g0 <= 1'b0;
      b0 <= 1'b0;
      r1 <= 1'b0;
      g1 <= 1'b0;
      b1 <= 1'b0;
    end else begin
      r0 <= (pix_hi[DW-1 -: CW]   > cycle);
      g0 <= (pix_hi[2*CW-1 -: CW] > cycle);
      b0 <= (pix_hi[CW-1:0]       > cycle);
      r1 <= (pix_lo[DW-1 -: CW]   > cycle);
      g1 <= (pix_lo[2*CW-1 -: CW] > cycle);
      b1 <= (pix_lo[CW-1:0]       > cycle);
    end
  end

  // A request arriving on a boundary edge while idle only becomes pending
  // there, so it is committed at the following boundary. Requests while
  // pending are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      front_sel  <= 1'b0;
      prev_cycle <= '0;
      swap_done  <= 1'b0;
    end else begin
      prev_cycle <= cycle;
      swap_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (swap_req) begin
            state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (boundary) begin
            front_sel <= ~front_sel;
            swap_done <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/frame_pwm.md
FRAME_PWM -- requirements
Module: frame_pwm

Interface
REQ-001 SHALL have parameter rows, default 8, meaning addressable row count per panel half.
REQ-002 SHALL have parameter columns, default 32, meaning pixels per line.
REQ-003 SHALL have parameter cycles, default 256, meaning PWM cycles per refresh; channel depth CW = clog2(cycles).
REQ-004 SHALL define AW = clog2(2*rows*columns) as the pixel address width; line index = addr / columns, pixel = addr % columns.
REQ-005 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- row  in  clog2(rows)  current row address from the display driver.
- column  in  clog2(columns)  current column from the display driver.
- cycle  in  CW  current PWM cycle from the display driver.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_addr  in  AW  pixel address.
- wr_data  in  3*CW  {red, green, blue}.
- swap_req  in  1  single-cycle commit of the back buffer.
- swap_pending  out  1  commit accepted, awaiting frame boundary.
- swap_done  out  1  one-cycle pulse on buffer exchange.
- r0 g0 b0  out  1 each  upper-half pixel bits (line = row).
- r1 g1 b1  out  1 each  lower-half pixel bits (line = row + rows).

Function
REQ-006 SHALL hold two banks of 2*rows*columns entries x 3*CW bits; front bank is read, back bank is written; a 1-bit front select names the front bank.
REQ-007 Write handshake: transfer occurs on a clk edge with wr_valid=1 and wr_ready=1; data is stored in the back bank at wr_addr.
REQ-008 wr_addr >= 2*rows*columns SHALL complete the handshake and leave memory unchanged.
REQ-009 wr_ready SHALL equal NOT swap_pending.
REQ-010 swap_req=1 with swap_pending=0 SHALL set swap_pending on the next edge; swap_req while pending is ignored.
REQ-011 A write and swap_req on the same edge SHALL both be accepted, and the write lands in the back bank before the exchange.
REQ-012 Frame boundary SHALL be detected as registered previous cycle == cycles-1 and current cycle == 0.
REQ-013 At a boundary edge with swap_pending=1 already set, the block SHALL toggle front select, clear swap_pending, and pulse swap_done for exactly one cycle.
REQ-014 swap_req coincident with a boundary, pending previously 0, SHALL be held pending until the next boundary.
REQ-015 Per edge, the block SHALL read the front-bank entries for line row and line row+rows at column, using two reads.
REQ-016 Each output bit SHALL be (channel value > cycle), registered, with a latency of exactly 1 clk from row/column/cycle.
REQ-017 Channel value 0 SHALL never light, and value cycles-1 SHALL light for cycles-1 of cycles; comparison is unsigned CW-bit.
REQ-018 Reads at a boundary edge SHALL use the pre-toggle front bank; the first read from the new bank occurs the following edge.
REQ-019 Inputs row/column/cycle SHALL be accepted at any value; out-of-range row/column read undefined data but must not corrupt state.

Reset
REQ-020 While rst=0 (asynchronous), the block SHALL drive r0..b1=0, swap_pending=0, swap_done=0, front select=0, previous-cycle register=0, and wr_ready=1.
REQ-021 Memory contents SHALL NOT be reset and SHALL be treated as undefined until written.
REQ-022 Reset asserted mid-pending SHALL discard the pending swap, and SHALL discard any write not completed before the reset edge.

Verification
REQ-023 Bench SHALL cover:
- Write addr 0 = 0x800000 to back, swap, then row=0,col=0 sweep cycle 0..255 -> r0=1 for cycle 0..127, 0 for 128..255, g0=b0=0.
- Write addr rows*columns (line 8) = 0x0000FF with cycles=256 -> b1=1 for cycle 0..254, 0 at 255; r0/g0/b0 unaffected.
- swap_req at cycle=100 -> swap_pending=1, wr_ready=0 until the edge where cycle goes 255->0, then swap_done=1 for one clk, wr_ready=1 next.
- swap_req on the boundary edge itself -> no swap there; swap_done on the following boundary, 256*... cycles later.
- Write wr_addr=2*rows*columns -> handshake completes, no memory change; back-bank readback after swap is unchanged.
- rst low while swap_pending=1 -> all outputs 0 immediately, without clk; after release, wr_ready=1 and front select=0.
